// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter slice: result-register state, requester id,
// ALUOp codes shared with alucontroller, and the ALU control encoding.
package alu_arb_pkg;

  typedef enum logic {
    EMPTY,
    FULL
  } res_state_t;

  typedef logic req_id_t;

  localparam logic [2:0] ALUOP_RTYPE  = 3'd0;
  localparam logic [2:0] ALUOP_ITYPE  = 3'd1;
  localparam logic [2:0] ALUOP_MEM    = 3'd2;
  localparam logic [2:0] ALUOP_BRANCH = 3'd3;
  localparam logic [2:0] ALUOP_LUI    = 3'd4;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU with zero flag.
import alu_arb_pkg::*;

module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  alu_ctrl_t             alu_ctrl,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  is_zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = in1[SHW-1:0];

  always_comb begin
    out = '0;
    case (alu_ctrl)
      ALU_ADD:    out = in0 + in1;
      ALU_SUB:    out = in0 - in1;
      ALU_SLL:    out = in0 << shamt;
      ALU_SLT:    out = {{(DATA_WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      ALU_SLTU:   out = {{(DATA_WIDTH-1){1'b0}}, (in0 < in1)};
      ALU_XOR:    out = in0 ^ in1;
      ALU_SRL:    out = in0 >> shamt;
      ALU_SRA:    out = $signed(in0) >>> shamt;
      ALU_OR:     out = in0 | in1;
      ALU_AND:    out = in0 & in1;
      ALU_PASS_B: out = in1;
      default:    out = '0;
    endcase
  end

  assign is_zero = (out == '0);

endmodule

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant: the pointer breaks ties, a lone requester always wins.
import alu_arb_pkg::*;

module alu_arb_rr (
  input  logic [1:0] valid,
  input  req_id_t    ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[0] && valid[1])
      grant[ptr] = 1'b1;
    else
      grant = valid;
  end

endmodule

// File: rtl/alucontroller.sv
// Decodes ALUOp plus funct7/funct3 into an ALU control code.
import alu_arb_pkg::*;

module alucontroller (
  input  logic [2:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output alu_ctrl_t  alu_ctrl
);

  logic alt;

  assign alt = (funct7 == FUNCT7_ALT);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (aluop)
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000: alu_ctrl = (aluop == ALUOP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_LUI:    alu_ctrl = ALU_PASS_B;
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters sharing one alucontroller+alu behind a one-entry result register.
// Define ALU_ARBITER_PERF_EN to add per-requester accept and stall counters.
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][2:0]            req_aluop,
  input  logic [NUM_REQ-1:0][6:0]            req_funct7,
  input  logic [NUM_REQ-1:0][2:0]            req_funct3,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_in0,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_in1,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_out,
  output logic                               rsp_is_zero
`ifdef ALU_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]           perf_grant_cnt,
  output logic [31:0]                        perf_stall_cnt
`endif
);

  res_state_t            state;
  req_id_t               owner;
  req_id_t               ptr;
  req_id_t               sel;
  logic [NUM_REQ-1:0]    grant;
  logic                  can_accept;
  logic                  accept;
  alu_ctrl_t             alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;

  alu_arb_rr u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign sel = grant[1];

  alucontroller u_ctrl (
    .aluop    (req_aluop[sel]),
    .funct7   (req_funct7[sel]),
    .funct3   (req_funct3[sel]),
    .alu_ctrl (alu_ctrl)
  );

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .in0      (req_in0[sel]),
    .in1      (req_in1[sel]),
    .alu_ctrl (alu_ctrl),
    .out      (alu_out),
    .is_zero  (alu_zero)
  );

  // A draining owner frees the register on the same edge, so a new op can land.
  assign can_accept = (state == EMPTY) || rsp_ready[owner];
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      owner       <= 1'b0;
      ptr         <= 1'b0;
      rsp_valid   <= '0;
      rsp_out     <= '0;
      rsp_is_zero <= 1'b0;
    end else if (accept) begin
      state       <= FULL;
      owner       <= sel;
      ptr         <= ~sel;
      rsp_valid   <= grant;
      rsp_out     <= alu_out;
      rsp_is_zero <= alu_zero;
    end else if (state == FULL && rsp_ready[owner]) begin
      state     <= EMPTY;
      rsp_valid <= '0;
    end
  end

`ifdef ALU_ARBITER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept)
        perf_grant_cnt[sel] <= perf_grant_cnt[sel] + 32'd1;
      if (|req_valid && !accept)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets operand/result width.
REQ-002 Parameter NUM_REQ, default 2, sets requester count; only 2 is supported.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  [NUM_REQ]  per-requester operation valid.
REQ-006 req_ready  out  [NUM_REQ]  per-requester accept; transfer = valid & ready at clk edge.
REQ-007 req_aluop  in  [NUM_REQ][3]  ALUOp code, alucontroller encoding.
REQ-008 req_funct7 / req_funct3  in  [NUM_REQ][7] / [NUM_REQ][3]  instruction function fields.
REQ-009 req_in0 / req_in1  in  [NUM_REQ][DATA_WIDTH]  operands.
REQ-010 rsp_valid  out  [NUM_REQ]  result valid for that requester.
REQ-011 rsp_ready  in  [NUM_REQ]  requester accepts result.
REQ-012 rsp_out  out  [DATA_WIDTH]  result; shared bus, qualified by rsp_valid.
REQ-013 rsp_is_zero  out  1  result == 0, qualified by rsp_valid.

Function
REQ-014 One shared alucontroller+alu pair; the granted request's fields drive it combinationally, result captured into a one-entry result register.
REQ-015 Result register state: EMPTY or FULL(owner); owner is 1 bit.
REQ-016 Arbitration round-robin: pointer names the preferred requester; if only one requester is valid, it is granted.
REQ-017 req_ready[i] = grant[i] & (EMPTY | rsp_ready[owner]); never asserted for a non-granted requester; at most one req_ready high per cycle.
REQ-018 On accept: capture out/is_zero and owner, go FULL, pointer := the other requester.
REQ-019 Latency: accept at edge N -> rsp_valid[owner] high after edge N, i.e. during cycle N+1.
REQ-020 rsp_valid[i] = FULL & owner==i; held with rsp_out/rsp_is_zero stable until rsp_ready[i].
REQ-021 Drain with no new accept -> EMPTY; drain and accept on the same edge -> stays FULL with the new owner (full throughput, one op/cycle).
REQ-022 Backpressure: while FULL and not draining, all req_ready low, and the pointer does not move.
REQ-023 rsp_ready of the non-owner is ignored.
REQ-024 Requester may drop req_valid without a transfer; no state change.

Reset
REQ-025 On rst: state EMPTY, owner 0, pointer 0, rsp_valid all 0, rsp_out 0, rsp_is_zero 0; effect is immediate (async).
REQ-026 Reset mid-operation discards any held result; no response is produced for it.
REQ-027 First cycle after reset release: req_ready follows REQ-017 (EMPTY).

Configuration
REQ-028 Macro ALU_ARBITER_PERF_EN, when defined, adds outputs perf_grant_cnt [NUM_REQ][32] (count of accepts per requester) and perf_stall_cnt [32] (count of cycles with some req_valid high and no accept); counters wrap modulo 2^32 and reset to 0.
REQ-029 Without ALU_ARBITER_PERF_EN these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package alu_arb_pkg holds: the result-state enum (EMPTY, FULL), the requester-id typedef, and the ALUOp code constants shared with alucontroller.
REQ-031 Sub-module alu_arb_rr (2-way round-robin grant from valid vector + pointer, purely combinational); existing alucontroller and alu are instantiated unmodified.

Verification
REQ-032 Req0 only, ALUOp 0, funct7 0, funct3 000, in0 5, in1 7, rsp_ready 1 -> req_ready0 same cycle, next cycle rsp_valid0, rsp_out 12, rsp_is_zero 0.
REQ-033 Both valid every cycle after reset, rsp_ready both 1 -> grants alternate 0,1,0,1; one response per cycle, each tagged to the correct requester.
REQ-034 Req1 SUB (funct7 0100000) in0 9, in1 9, rsp_ready1 low 3 cycles -> rsp_valid1 held, rsp_out 0, rsp_is_zero 1 stable; no req_ready during stall; accept resumes on the drain edge.
REQ-035 Req0 SRA, in0 0x80000000, in1 4, while FULL for req1 -> result 0xF8000000 to requester 0 only after req1 drains.
REQ-036 Assert rst while FULL -> rsp_valid 0 immediately, rsp_out 0; after release, the next accept goes to requester 0.
REQ-037 With ALU_ARBITER_PERF_EN: 5 accepts req0, 3 accepts req1, 2 stalled cycles -> perf_grant_cnt {5,3}, perf_stall_cnt 2.
